// File: rtl/mux_frame_scheduler_if.sv
// rtl/mux_frame_scheduler_if.sv - mux selector and serial TX handshake bundle
// Purpose: groups the scheduler's two bus-side links in one interface.
//   mux link : selector, data_lock (scheduler -> mux), mux_data (mux -> scheduler)
//   tx link  : tx_data, tx_valid (scheduler -> transmitter), tx_ready (transmitter -> scheduler)
// Modports: master = scheduler side, slave = mux/transmitter side.
interface mux_frame_scheduler_if #(
  parameter int SEL_W  = 8,
  parameter int DATA_W = 16
);
  logic [SEL_W-1:0]  selector;
  logic              data_lock;
  logic [DATA_W-1:0] mux_data;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output selector, data_lock, tx_data, tx_valid,
    input  mux_data, tx_ready
  );

  modport slave (
    input  selector, data_lock, tx_data, tx_valid,
    output mux_data, tx_ready
  );
endinterface

// File: rtl/mux_frame_scheduler.sv
// rtl/mux_frame_scheduler.sv - steps the telemetry mux and streams one serial frame
// Purpose: on start, walks the mux selector over word indices 0..NUM_WORDS-1, strobes
//   data_lock, captures the registered mux output and hands each word to the serial
//   transmitter over valid/ready; optionally appends a modulo-2^16 checksum word.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   start       : frame request level, only looked at while idle
//   bus         : master side of mux_frame_scheduler_if (selector/data_lock/mux_data,
//                 tx_data/tx_valid/tx_ready)
//   busy        : high from leaving idle until back in idle
//   frame_done  : one-cycle pulse after the last word of a frame is accepted
//   frame_cnt   : completed frames, wraps at 16 bits
module mux_frame_scheduler #(
  parameter int NUM_WORDS = 32,
  parameter int SEL_W     = 8,
  parameter int DATA_W    = 16,
  parameter bit CSUM_EN   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  mux_frame_scheduler_if.master  bus,
  output logic                   busy,
  output logic                   frame_done,
  output logic [15:0]            frame_cnt
);

  typedef enum logic [2:0] {
    IDLE, LOCK, WAIT, LOAD, SEND, CSUM, DONE
  } state_t;

  state_t            state, next_state;
  logic [SEL_W-1:0]  idx;
  logic [DATA_W-1:0] sum;
  logic              last_word;

  assign last_word = (idx == SEL_W'(NUM_WORDS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = LOCK;
      LOCK: next_state = WAIT;
      WAIT: next_state = LOAD;
      LOAD: next_state = SEND;
      SEND: begin
        if (bus.tx_ready) begin
          if (!last_word)   next_state = LOCK;
          else if (CSUM_EN) next_state = CSUM;
          else              next_state = DONE;
        end
      end
      // First CSUM cycle only loads the sum; the accept can come from the second on.
      CSUM: if (bus.tx_valid && bus.tx_ready) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from state; the selector is the word index register itself,
  // which only moves on the transitions into LOCK.
  always_comb begin
    bus.selector  = idx;
    bus.data_lock = (state == LOCK);
    busy          = (state != IDLE);
    frame_done    = (state == DONE);
  end

  // Datapath: word index, checksum, transmit holding register, frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      idx          <= '0;
      sum          <= '0;
      bus.tx_data  <= '0;
      bus.tx_valid <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx <= '0;
            sum <= '0;
          end
        end
        LOAD: begin
          bus.tx_data  <= bus.mux_data;
          bus.tx_valid <= 1'b1;
          sum          <= sum + bus.mux_data;
        end
        SEND: begin
          if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            if (!last_word) idx <= idx + 1'b1;
          end
        end
        CSUM: begin
          if (!bus.tx_valid) begin
            bus.tx_data  <= sum;
            bus.tx_valid <= 1'b1;
          end else if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
          end
        end
        DONE: frame_cnt <= frame_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_frame_scheduler.sv
// tb/tb_mux_frame_scheduler.sv - self-checking bench for mux_frame_scheduler
module tb_mux_frame_scheduler;
  logic clk = 1'b0;
  logic reset;
  logic start    [3];
  logic tx_ready [3];

  logic [7:0]  sel_w [3];
  logic        dl_w  [3];
  logic [15:0] td_w  [3];
  logic        tv_w  [3];
  logic        busy_w[3];
  logic        fd_w  [3];
  logic [15:0] fc_w  [3];

  logic [15:0] mux_tab    [3][32];
  logic [15:0] mux_data_r [3] = '{default: 16'h0};
  logic        dl_prev    [3] = '{default: 1'b0};
  int          lock_edges [3] = '{default: 0};
  int          acc_cnt    [3] = '{default: 0};
  int          exp_cnt    [3];
  logic [15:0] exp_w      [33];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Three instances: 4 words + checksum, 32 words + checksum, 1 word without checksum
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NW = (g == 0) ? 4 : ((g == 1) ? 32 : 1);
    localparam bit CE = (g == 2) ? 1'b0 : 1'b1;
    mux_frame_scheduler_if #(.SEL_W(8), .DATA_W(16)) bus ();
    assign bus.mux_data = mux_data_r[g];
    assign bus.tx_ready = tx_ready[g];
    assign sel_w[g] = bus.selector;
    assign dl_w[g]  = bus.data_lock;
    assign td_w[g]  = bus.tx_data;
    assign tv_w[g]  = bus.tx_valid;
    mux_frame_scheduler #(.NUM_WORDS(NW), .SEL_W(8), .DATA_W(16), .CSUM_EN(CE)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start[g]),
      .bus        (bus.master),
      .busy       (busy_w[g]),
      .frame_done (fd_w[g]),
      .frame_cnt  (fc_w[g])
    );
  end

  // Registered mux model plus counters of lock pulses and accepted words
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (dl_w[g]) mux_data_r[g] <= mux_tab[g][sel_w[g][4:0]];
      if (dl_w[g] && !dl_prev[g]) lock_edges[g] <= lock_edges[g] + 1;
      dl_prev[g] <= dl_w[g];
      if (tv_w[g] && tx_ready[g]) acc_cnt[g] <= acc_cnt[g] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int nw_of(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 32 : 1);
  endfunction

  task automatic fill_random(input int g);
    for (int i = 0; i < 32; i++) mux_tab[g][i] = 16'($urandom);
  endtask

  // Called at the negedge of the idle cycle in which start is high.
  // sw/sl: hold tx_ready low for sl valid cycles on word sw of the frame.
  task automatic do_frame(input int g, input bit hold, input int poke,
                          input int sw, input int sl, input int abort_after);
    int nw, ce, nexp, lb, ab, stalled, cyc, tmo;
    logic [15:0] s;
    bit fin;
    nw = nw_of(g);
    ce = (g == 2) ? 0 : 1;
    s = 16'h0;
    for (int i = 0; i < nw; i++) begin
      exp_w[i] = mux_tab[g][i];
      s = 16'(s + mux_tab[g][i]);
    end
    exp_w[nw] = s;
    nexp = nw + ce;
    tmo = 4 * nw + 2 * ce + 1 + sl;
    lb = lock_edges[g];
    ab = acc_cnt[g];
    stalled = 0;
    cyc = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check("busy_rise", busy_w[g], 1);
        check("first_lock", dl_w[g], 1);
        if (!hold) start[g] = 1'b0;
      end
      if (poke > 0 && cyc == poke) start[g] = 1'b1;
      if (poke > 0 && cyc == poke + 1) start[g] = 1'b0;
      if (dl_w[g]) check("selector", sel_w[g], lock_edges[g] - lb);
      if (tv_w[g]) begin
        check("tx_data", td_w[g], exp_w[acc_cnt[g] - ab]);
        if (acc_cnt[g] - ab == sw && stalled < sl) begin
          tx_ready[g] = 1'b0;
          stalled++;
        end else begin
          tx_ready[g] = 1'b1;
        end
      end else begin
        tx_ready[g] = 1'b1;
      end
      if (abort_after > 0 && stalled == abort_after) return;
      if (fd_w[g]) fin = 1'b1;
      else if (cyc > tmo + 50) begin
        check("frame_timeout", cyc, tmo);
        fin = 1'b1;
      end
    end
    tx_ready[g] = 1'b1;
    check("frame_len", cyc, tmo);
    check("word_count", acc_cnt[g] - ab, nexp);
    check("lock_pulses", lock_edges[g] - lb, nw);
    exp_cnt[g] = (exp_cnt[g] + 1) & 32'hFFFF;
    @(negedge clk);
    check("done_pulse_width", fd_w[g], 0);
    check("busy_idle", busy_w[g], 0);
    check("frame_cnt", fc_w[g], exp_cnt[g]);
  endtask

  initial begin
    reset = 1'b1;
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0;
      tx_ready[g] = 1'b1;
      exp_cnt[g] = 0;
      for (int i = 0; i < 32; i++) mux_tab[g][i] = 16'h0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_selector", sel_w[g], 0);
      check("rst_data_lock", dl_w[g], 0);
      check("rst_tx_data", td_w[g], 0);
      check("rst_tx_valid", tv_w[g], 0);
      check("rst_busy", busy_w[g], 0);
      check("rst_frame_done", fd_w[g], 0);
      check("rst_frame_cnt", fc_w[g], 0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Ramp data, clean frame: words 0x0001,0x0101,0x0201,0x0301 and checksum 0x0604
    for (int i = 0; i < 32; i++) mux_tab[0][i] = 16'(32'h100 * i + 1);
    start[0] = 1'b1;
    do_frame(0, 1'b0, 0, 99, 0, 0);
    check("ramp_checksum", exp_w[4], 16'h0604);

    // Same data, five-cycle transmitter stall on word 2
    @(negedge clk);
    start[0] = 1'b1;
    do_frame(0, 1'b0, 0, 2, 5, 0);

    // Random data with random stalls, including on the checksum word
    for (int k = 0; k < 3; k++) begin
      fill_random(0);
      @(negedge clk);
      start[0] = 1'b1;
      do_frame(0, 1'b0, 0, $urandom_range(0, 4), $urandom_range(0, 6), 0);
    end

    // Start held: three back-to-back frames with one idle cycle between them
    fill_random(0);
    @(negedge clk);
    start[0] = 1'b1;
    do_frame(0, 1'b1, 0, 99, 0, 0);
    do_frame(0, 1'b1, 0, 99, 0, 0);
    do_frame(0, 1'b0, 0, 99, 0, 0);
    @(negedge clk);
    check("no_restart", busy_w[0], 0);

    // 32 words of 0xFFFF: checksum wraps to 0xFFE0
    for (int i = 0; i < 32; i++) mux_tab[1][i] = 16'hFFFF;
    @(negedge clk);
    start[1] = 1'b1;
    do_frame(1, 1'b0, 0, 99, 0, 0);
    check("wrap_checksum", exp_w[32], 16'hFFE0);

    for (int k = 0; k < 2; k++) begin
      fill_random(1);
      @(negedge clk);
      start[1] = 1'b1;
      do_frame(1, 1'b0, 0, $urandom_range(0, 32), $urandom_range(0, 6), 0);
    end

    // Single word, no checksum; a start pulse while busy must not spawn a frame
    fill_random(2);
    @(negedge clk);
    start[2] = 1'b1;
    do_frame(2, 1'b0, 2, 99, 0, 0);
    @(negedge clk);
    check("busy_start_ignored", busy_w[2], 0);
    fill_random(2);
    start[2] = 1'b1;
    do_frame(2, 1'b0, 0, 0, $urandom_range(1, 4), 0);

    // Reset while stalled in SEND on word 10, then a fresh frame from index 0
    fill_random(1);
    @(negedge clk);
    start[1] = 1'b1;
    do_frame(1, 1'b0, 0, 10, 100, 3);
    reset = 1'b1;
    @(negedge clk);
    check("abort_selector", sel_w[1], 0);
    check("abort_data_lock", dl_w[1], 0);
    check("abort_tx_data", td_w[1], 0);
    check("abort_tx_valid", tv_w[1], 0);
    check("abort_busy", busy_w[1], 0);
    check("abort_frame_done", fd_w[1], 0);
    check("abort_frame_cnt", fc_w[1], 0);
    check("abort_frame_cnt_other", fc_w[0], 0);
    for (int g = 0; g < 3; g++) exp_cnt[g] = 0;
    reset = 1'b0;
    tx_ready[1] = 1'b1;
    @(negedge clk);
    fill_random(1);
    start[1] = 1'b1;
    do_frame(1, 1'b0, 0, 99, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
